// File: rtl/abus_pkg.sv
// ---------------------------------------------------------------------------
// abus_pkg
// Shared definitions for the abus requester:
//   - abus_state_e : burst FSM states (IDLE, REQ, OWN, REL)
//   - LEN_W_DEF    : default burst length field width
//   - TIMEOUT_DEF  : default starvation threshold in cycles
//   - cnt_width()  : bits needed to hold 0..max_val inclusive
// ---------------------------------------------------------------------------
package abus_pkg;

  localparam int unsigned LEN_W_DEF   = 4;
  localparam int unsigned TIMEOUT_DEF = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_OWN  = 2'd2,
    ST_REL  = 2'd3
  } abus_state_e;

  // Width of a counter that must represent every value from 0 to max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/abus_req_if.sv
// ---------------------------------------------------------------------------
// abus_req_if
// Command, arbitration and beat handshake bundle of one abus requester.
//   cmd_valid/cmd_ready/cmd_len : user command handshake (cmd_len = beats-1)
//   req/grant                   : arbiter request (registered) / grant (comb)
//   beat_valid/beat_ready       : per-beat handshake toward downstream
//   busy/done/starved           : status
// Modports:
//   master : the requester block itself
//   slave  : the environment (user, arbiter, downstream sink)
// ---------------------------------------------------------------------------
interface abus_req_if #(
  parameter int LEN_W = abus_pkg::LEN_W_DEF
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [LEN_W-1:0] cmd_len;
  logic             req;
  logic             grant;
  logic             beat_valid;
  logic             beat_ready;
  logic             busy;
  logic             done;
  logic             starved;

  modport master (
    input  cmd_valid, cmd_len, grant, beat_ready,
    output cmd_ready, req, beat_valid, busy, done, starved
  );

  modport slave (
    output cmd_valid, cmd_len, grant, beat_ready,
    input  cmd_ready, req, beat_valid, busy, done, starved
  );

endinterface

// File: rtl/abus_sat_cnt.sv
// ---------------------------------------------------------------------------
// abus_sat_cnt
// Saturating up-counter with synchronous clear.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, clears the count
//   inc   : count up by one this cycle (ignored once saturated)
//   clr   : clear to zero; wins over inc
//   sat   : high while the count equals MAX
// ---------------------------------------------------------------------------
module abus_sat_cnt #(
  parameter int unsigned MAX = abus_pkg::TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int unsigned W = abus_pkg::cnt_width(MAX);

  logic [W-1:0] cnt;

  assign sat = (cnt == W'(MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !sat) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/abus_req.sv
// ---------------------------------------------------------------------------
// abus_req
// Bus requester: accepts one burst command, requests the abus, streams the
// burst beats while granted and then releases the bus for one cycle so that
// lower-priority masters get a chance to win arbitration.
// Ports:
//   clk   : clock, all state on rising edge
//   rst_n : asynchronous active-low reset
//   bus   : abus_req_if.master (command, req/grant, beat handshake, status)
// Parameters:
//   LEN_W   : width of cmd_len; a burst is cmd_len+1 beats (max 2**LEN_W)
//   TIMEOUT : cycles of req-without-grant before starved asserts (2..65535)
// ---------------------------------------------------------------------------
module abus_req
  import abus_pkg::*;
#(
  parameter int LEN_W   = LEN_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  abus_req_if.master bus
);

  abus_state_e      state;
  abus_state_e      state_nxt;
  logic [LEN_W-1:0] beat_cnt;
  logic [LEN_W-1:0] beat_cnt_nxt;
  logic             req_q;
  logic             req_nxt;
  logic             xfer;
  logic             wait_inc;
  logic             wait_sat;

  // Beat offer follows grant combinationally so a dropped grant withdraws
  // the beat in the very same cycle.
  assign bus.beat_valid = (state == ST_OWN) && bus.grant;
  assign xfer           = bus.beat_valid && bus.beat_ready;

  assign bus.cmd_ready  = (state == ST_IDLE);
  assign bus.busy       = (state != ST_IDLE);
  assign bus.done       = (state == ST_REL);
  assign bus.req        = req_q;
  assign bus.starved    = wait_sat;

  // Beat counter holds beats remaining minus one; the beat taken while it is
  // zero is the last one, so the counter never has to wrap.
  always_comb begin
    state_nxt    = state;
    beat_cnt_nxt = beat_cnt;
    unique case (state)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          state_nxt    = ST_REQ;
          beat_cnt_nxt = bus.cmd_len;
        end
      end
      ST_REQ: begin
        if (bus.grant) begin
          state_nxt = ST_OWN;
        end
      end
      ST_OWN: begin
        if (xfer) begin
          if (beat_cnt == '0) begin
            state_nxt = ST_REL;
          end else begin
            beat_cnt_nxt = beat_cnt - LEN_W'(1);
          end
        end
      end
      ST_REL: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
    // req is computed from the next state and registered, so the arbiter
    // sees a glitch-free line that rises the cycle after acceptance.
    req_nxt = (state_nxt == ST_REQ) || (state_nxt == ST_OWN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      beat_cnt <= '0;
      req_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      beat_cnt <= beat_cnt_nxt;
      req_q    <= req_nxt;
    end
  end

  // Starvation tracking: every cycle spent requesting without grant counts,
  // including grant loss mid-burst; the count only clears at burst end.
  assign wait_inc = req_q && !bus.grant;

  abus_sat_cnt #(
    .MAX (TIMEOUT)
  ) u_wait_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (wait_inc),
    .clr   (bus.done),
    .sat   (wait_sat)
  );

endmodule

// File: tb/tb_abus_req.sv
module tb_abus_req;

  localparam int LW  = 4;
  localparam int TMO = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    #1;
  endtask

  // ---------------- main DUT ----------------
  abus_req_if #(.LEN_W(LW)) bus();
  abus_req #(.LEN_W(LW), .TIMEOUT(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural model: a burst is pending from acceptance until its done
  // cycle; it owns the bus after the first granted edge; 'left' counts beats
  // still to move; 'fin' marks the single release/done cycle.
  bit m_pend, m_own, m_fin;
  int m_left, m_wait;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend <= 1'b0; m_own <= 1'b0; m_fin <= 1'b0; m_left <= 0; m_wait <= 0;
    end else if (m_fin) begin
      m_fin <= 1'b0; m_pend <= 1'b0; m_wait <= 0;
    end else if (!m_pend) begin
      if (bus.cmd_valid) begin
        m_pend <= 1'b1;
        m_left <= int'(bus.cmd_len) + 1;
      end
    end else begin
      if (!bus.grant && m_wait < TMO) m_wait <= m_wait + 1;
      if (!m_own) m_own <= bus.grant;
      else if (bus.grant && bus.beat_ready) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_own <= 1'b0;
          m_fin <= 1'b1;
        end
      end
    end
  end

  bit cmp_on = 1'b0;
  always @(negedge clk) begin
    if (cmp_on) begin
      check("cmp_req",        bus.req,        32'(m_pend && !m_fin));
      check("cmp_beat_valid", bus.beat_valid, 32'(m_own && bus.grant));
      check("cmp_busy",       bus.busy,       32'(m_pend));
      check("cmp_done",       bus.done,       32'(m_fin));
      check("cmp_cmd_ready",  bus.cmd_ready,  32'(!m_pend));
      check("cmp_starved",    bus.starved,    32'(m_wait >= TMO));
    end
  end

  // ---------------- eight requesters on a fixed-priority arbiter ----------------
  logic [7:0] a_req, a_gnt, a_bv, a_done;
  logic       a_cmd_valid = 1'b0;

  for (genvar g = 0; g < 8; g++) begin : g_m
    abus_req_if #(.LEN_W(LW)) b();
    abus_req #(.LEN_W(LW), .TIMEOUT(64)) u (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b)
    );
    assign b.cmd_valid  = a_cmd_valid;
    assign b.cmd_len    = '0;
    assign b.grant      = a_gnt[g];
    assign b.beat_ready = 1'b1;
    assign a_req[g]     = b.req;
    assign a_bv[g]      = b.beat_valid;
    assign a_done[g]    = b.done;
  end

  // Lowest index wins.
  always_comb begin
    a_gnt = '0;
    for (int i = 7; i >= 0; i--) begin
      if (a_req[i]) begin
        a_gnt    = '0;
        a_gnt[i] = 1'b1;
      end
    end
  end

  function automatic int low_idx(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return -1;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int x, done_k, k4, nd;
    bit seen;
    bus.cmd_valid = 1'b0; bus.cmd_len = '0; bus.grant = 1'b0; bus.beat_ready = 1'b0;

    // reset state
    #1 rst_n = 1'b0;
    #2;
    check("rst_req", bus.req, 0);
    check("rst_beat_valid", bus.beat_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_starved", bus.starved, 0);
    check("rst_cmd_ready", bus.cmd_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cmp_on = 1'b1;

    // len=3, grant and beat_ready tied high
    bus.grant = 1'b1; bus.beat_ready = 1'b1; bus.cmd_len = 4'd3; bus.cmd_valid = 1'b1;
    look();
    check("s1_cmd_ready", bus.cmd_ready, 1);
    check("s1_req_before", bus.req, 0);
    step(); bus.cmd_valid = 1'b0; look();
    check("s1_req_rise", bus.req, 1);
    check("s1_dead_cycle", bus.beat_valid, 0);
    step();
    for (int i = 0; i < 4; i++) begin
      look();
      check("s1_beat", bus.beat_valid, 1);
      check("s1_no_done", bus.done, 0);
      step();
    end
    look();
    check("s1_rel_req", bus.req, 0);
    check("s1_rel_done", bus.done, 1);
    step(); look();
    check("s1_done_pulse", bus.done, 0);
    check("s1_idle_ready", bus.cmd_ready, 1);

    // len=3, beat_ready toggling
    bus.cmd_len = 4'd3; bus.cmd_valid = 1'b1; bus.beat_ready = 1'b0;
    step(); bus.cmd_valid = 1'b0;
    step();
    x = 0; seen = 1'b0; done_k = -1; k4 = -1;
    for (int k = 0; k < 20 && !seen; k++) begin
      bus.beat_ready = (k % 2 == 0);
      look();
      if (bus.done) begin seen = 1'b1; done_k = k; end
      else if (bus.beat_valid && bus.beat_ready) begin x++; if (x == 4) k4 = k; end
      step();
    end
    check("s2_xfers", x, 4);
    check("s2_done_seen", seen, 1);
    check("s2_done_after_4th", done_k, k4 + 1);
    check("s2_done_k", done_k, 7);

    // grant dropped for 5 cycles after beat 2
    bus.cmd_len = 4'd3; bus.cmd_valid = 1'b1; bus.beat_ready = 1'b1; bus.grant = 1'b1;
    step(); bus.cmd_valid = 1'b0;
    step();
    for (int i = 0; i < 2; i++) begin
      look(); check("s3_beat_pre", bus.beat_valid, 1); step();
    end
    bus.grant = 1'b0;
    for (int i = 0; i < 5; i++) begin
      look();
      check("s3_drop_bv", bus.beat_valid, 0);
      check("s3_drop_req", bus.req, 1);
      step();
    end
    bus.grant = 1'b1;
    x = 0; seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      look();
      if (bus.done) seen = 1'b1;
      else if (bus.beat_valid && bus.beat_ready) x++;
      step();
    end
    check("s3_resume_beats", x, 2);
    check("s3_done_seen", seen, 1);

    // starvation: grant held low for 20 cycles
    bus.cmd_len = 4'd0; bus.cmd_valid = 1'b1; bus.grant = 1'b0;
    step(); bus.cmd_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      look();
      check("s4_starved", bus.starved, 32'(k >= 16));
      step();
    end
    bus.grant = 1'b1; look();
    check("s4_hold_grant", bus.starved, 1);
    step(); look();
    check("s4_hold_own", bus.starved, 1);
    check("s4_own_beat", bus.beat_valid, 1);
    step(); look();
    check("s4_done", bus.done, 1);
    check("s4_hold_rel", bus.starved, 1);
    step(); look();
    check("s4_cleared", bus.starved, 0);

    // asynchronous reset while owning the bus
    bus.cmd_len = 4'd5; bus.cmd_valid = 1'b1; bus.grant = 1'b1; bus.beat_ready = 1'b0;
    step(); bus.cmd_valid = 1'b0;
    step(); look();
    check("s5_own_bv", bus.beat_valid, 1);
    rst_n = 1'b0; #1;
    check("s5_rst_req", bus.req, 0);
    check("s5_rst_bv", bus.beat_valid, 0);
    check("s5_rst_busy", bus.busy, 0);
    check("s5_rst_ready", bus.cmd_ready, 1);
    @(posedge clk); #1 rst_n = 1'b1;
    look();
    check("s5_post_ready", bus.cmd_ready, 1);
    check("s5_post_req", bus.req, 0);

    // randomized traffic, model compared every cycle
    for (int c = 0; c < 600; c++) begin
      bus.cmd_valid  = ($urandom_range(0, 3) == 0);
      bus.cmd_len    = 4'($urandom_range(0, 15));
      bus.grant      = (c < 350) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
      bus.beat_ready = $urandom_range(0, 1);
      step();
    end
    bus.cmd_valid = 1'b0; bus.grant = 1'b1; bus.beat_ready = 1'b1;
    repeat (40) step();
    look();
    check("s6_drained", bus.cmd_ready, 1);

    // eight requesters, all issue single-beat bursts together
    a_cmd_valid = 1'b1;
    step(); a_cmd_valid = 1'b0; look();
    check("s7_all_req", a_req, 8'hFF);
    nd = 0;
    for (int c = 0; c < 40; c++) begin
      look();
      if (a_req != '0) check("s7_gnt_onehot", $onehot(a_gnt), 1);
      check("s7_bv_onehot0", $onehot0(a_bv), 1);
      if (a_done != '0) begin
        check("s7_done_single", $onehot(a_done), 1);
        check("s7_done_order", low_idx(a_done), nd);
        nd++;
      end
      step();
    end
    check("s7_all_done", nd, 8);

    cmp_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/abus_req.md
ABUS_REQ -- requirements
Module: abus_req

Interface
REQ-001 The block SHALL have parameter LEN_W, default 4: width of the burst length field.
REQ-002 The block SHALL have parameter TIMEOUT, default 64: cycles of unserved request before starved asserts, legal range 2..65535.
REQ-003 The block SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have port cmd_valid  input  1  user asks for bus ownership for one burst.
REQ-006 The block SHALL have port cmd_ready  output  1  block can accept a command.
REQ-007 The block SHALL have port cmd_len  input  LEN_W  burst beats minus one, so 0 means 1 beat.
REQ-008 The block SHALL have port req  output  1  request line to the abus arbiter, registered.
REQ-009 The block SHALL have port grant  input  1  grant from the arbiter, combinational, may drop at any cycle.
REQ-010 The block SHALL have port beat_valid  output  1  bus owned and a beat is offered.
REQ-011 The block SHALL have port beat_ready  input  1  downstream accepts the offered beat.
REQ-012 The block SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-013 The block SHALL have port done  output  1  one-cycle pulse at burst completion.
REQ-014 The block SHALL have port starved  output  1  wait counter saturated at TIMEOUT.

Function
REQ-015 The FSM SHALL have states IDLE, REQ, OWN and REL.
REQ-016 cmd_ready SHALL be (state==IDLE); a command is accepted when cmd_valid and cmd_ready are both high, which latches cmd_len into the beat counter and moves to REQ.
REQ-017 req SHALL be high in REQ and OWN only, i.e. high from the cycle after acceptance.
REQ-018 In REQ, grant=1 at a rising edge SHALL move the FSM to OWN, giving one dead cycle between first grant and first beat.
REQ-019 beat_valid SHALL be (state==OWN) and grant, combinational, so a dropped grant withdraws the beat in the same cycle.
REQ-020 A beat SHALL transfer when beat_valid and beat_ready are both high; each transfer decrements the beat counter.
REQ-021 Grant loss in OWN SHALL keep the FSM in OWN with req high and the counter unchanged; the burst resumes when grant returns, with no beat lost or duplicated.
REQ-022 The transfer with counter==0 SHALL move the FSM to REL; in REL, req=0 and done=1 for exactly one cycle, then the FSM returns to IDLE.
REQ-023 The mandatory REL cycle with req low SHALL allow lower-priority masters to win arbitration; back-to-back commands are therefore separated by at least 2 cycles of req low (REL, IDLE).
REQ-024 The wait counter SHALL increment on every cycle where req=1 and grant=0, saturate at TIMEOUT, and clear on done.
REQ-025 starved SHALL be (wait counter == TIMEOUT), remaining high until done even if grant returns.
REQ-026 cmd_valid while busy SHALL be ignored, with no queueing.
REQ-027 The beat counter SHALL be LEN_W bits and never wrap; the maximum burst is 2**LEN_W beats.

Reset
REQ-028 rst_n low SHALL asynchronously force state to IDLE and the beat and wait counters to 0.
REQ-029 During reset, outputs SHALL be req=0, beat_valid=0, busy=0, done=0, starved=0 and cmd_ready=1.
REQ-030 Reset mid-burst SHALL drop req immediately, discarding the remaining beats; deassertion is synchronised externally.

Structure
REQ-031 The package abus_pkg SHALL hold the FSM state enum typedef and the default LEN_W/TIMEOUT constants.
REQ-032 One sub-module, abus_sat_cnt, SHALL implement the saturating wait counter, parameterised by max value.
REQ-033 The implementation SHALL use no other hierarchy and no memories.

Verification
REQ-034 The bench SHALL cover: cmd_len=3, grant and beat_ready tied 1 -> req rises 1 cycle after accept, 4 consecutive beat_valid cycles, done pulse, req=0 in REL.
REQ-035 The bench SHALL cover: cmd_len=3, beat_ready toggling 1,0,1,0 -> exactly 4 transfers, done after the 4th.
REQ-036 The bench SHALL cover: cmd_len=3, grant dropped for 5 cycles after beat 2 -> beat_valid=0 and req=1 throughout the drop, then 2 more beats, no duplicate.
REQ-037 The bench SHALL cover: TIMEOUT=16, grant held 0 for 20 cycles -> starved rises on wait cycle 16 and clears on done.
REQ-038 The bench SHALL cover: rst_n pulsed low during OWN -> req, beat_valid and busy fall without a clock edge; after release cmd_ready=1.
REQ-039 The bench SHALL cover: 8 instances on abus_lf N=8, all issuing cmd_len=0 together -> grant one-hot every cycle, instances complete in ascending index order, all 8 done pulses within 40 cycles.
